// File: rtl/rename_register_file.sv
// -----------------------------------------------------------------------------
// rename_register_file
//
// Architectural register file with per-register rename tags. It sits between
// the Dispatcher and the reorder buffer:
//   * the commit port takes the RoB's RF_update stream (en/reg/index/data) and
//     writes committed values, clearing the busy bit when the committing RoB
//     entry is still the register's most recent producer;
//   * the rename port records which RoB entry will produce a destination;
//   * two combinational lookups return either a value or a pending RoB tag,
//     with a same-cycle bypass from the commit port.
// A flush clears every busy bit; committed values are kept.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  low = pause, all state held
//   flush_signal            mispredict flush, clears every busy bit
//   rename_en/rd/index      destination rename from the Dispatcher
//   commit_en/reg/index/data  RoB commit write
//   rs1_addr -> rs1_busy/tag/value   source lookup 1 (combinational)
//   rs2_addr -> rs2_busy/tag/value   source lookup 2 (combinational)
//
// Optional feature (macro RENAME_REGFILE_DEBUG_EN)
//   Adds debug_write_en/debug_write_reg/debug_write_data, registered one cycle
//   after each accepted commit to a nonzero register, plus an internal 32-bit
//   write counter. Without the macro these do not exist.
// -----------------------------------------------------------------------------
module rename_register_file #(
    parameter int RoB_WIDTH = 3,
    parameter int REG_NUM   = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_signal,
    input  logic                 rename_en,
    input  logic [4:0]           rename_rd,
    input  logic [RoB_WIDTH-1:0] rename_index,
    input  logic                 commit_en,
    input  logic [4:0]           commit_reg,
    input  logic [RoB_WIDTH-1:0] commit_index,
    input  logic [31:0]          commit_data,
    input  logic [4:0]           rs1_addr,
    output logic                 rs1_busy,
    output logic [RoB_WIDTH-1:0] rs1_tag,
    output logic [31:0]          rs1_value,
    input  logic [4:0]           rs2_addr,
    output logic                 rs2_busy,
    output logic [RoB_WIDTH-1:0] rs2_tag,
    output logic [31:0]          rs2_value
`ifdef RENAME_REGFILE_DEBUG_EN
    ,
    output logic                 debug_write_en,
    output logic [4:0]           debug_write_reg,
    output logic [31:0]          debug_write_data
`endif
);

    logic [31:0]          value_reg  [REG_NUM];
    logic [31:0]          value_next [REG_NUM];
    logic [RoB_WIDTH-1:0] tag_reg    [REG_NUM];
    logic [RoB_WIDTH-1:0] tag_next   [REG_NUM];
    logic [REG_NUM-1:0]   busy_reg;
    logic [REG_NUM-1:0]   busy_next;

    logic commit_valid;
    logic rename_valid;

    // Register 0 is excluded here so it never gets written or renamed.
    assign commit_valid = commit_en && (commit_reg != 5'd0);
    assign rename_valid = rename_en && !flush_signal && (rename_rd != 5'd0);

    genvar gi;

    // Per-register next-state decode.
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign value_next[gi] = '0;
                assign tag_next[gi]   = '0;
                assign busy_next[gi]  = 1'b0;
            end else begin : g_arch
                logic commit_hit;
                logic rename_hit;
                logic producer_done;

                assign commit_hit    = commit_valid && (commit_reg == 5'(gi));
                assign rename_hit    = rename_valid && (rename_rd == 5'(gi));
                // Only the most recent producer may retire the busy bit; an
                // older (stale) commit still updates the value.
                assign producer_done = commit_hit && (tag_reg[gi] == commit_index);

                assign value_next[gi] = commit_hit ? commit_data : value_reg[gi];
                assign tag_next[gi]   = rename_hit ? rename_index : tag_reg[gi];
                // Flush beats everything; a fresh rename beats a same-cycle
                // commit of the previous producer.
                assign busy_next[gi]  = flush_signal  ? 1'b0 :
                                        rename_hit    ? 1'b1 :
                                        producer_done ? 1'b0 : busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_reg[i] <= '0;
                tag_reg[i]   <= '0;
            end
            busy_reg <= '0;
        end else if (rdy_in) begin
            value_reg <= value_next;
            tag_reg   <= tag_next;
            busy_reg  <= busy_next;
        end
    end

    // Source lookups: read pre-edge state, with bypass from the commit port.
    logic [4:0]           rs_addr  [2];
    logic                 rs_busy  [2];
    logic [RoB_WIDTH-1:0] rs_tag   [2];
    logic [31:0]          rs_value [2];

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            logic [4:0] addr;
            logic       is_zero;
            logic       stored_busy;
            logic       bypass;

            assign addr        = rs_addr[gi];
            assign is_zero     = (addr == 5'd0);
            assign stored_busy = !is_zero && busy_reg[addr];
            assign bypass      = stored_busy && commit_en && (commit_reg == addr) &&
                                 (commit_index == tag_reg[addr]);

            assign rs_busy[gi]  = stored_busy && !bypass;
            assign rs_tag[gi]   = is_zero ? '0 : tag_reg[addr];
            assign rs_value[gi] = is_zero ? 32'd0 :
                                  bypass  ? commit_data : value_reg[addr];
        end
    endgenerate

    assign rs1_busy  = rs_busy[0];
    assign rs1_tag   = rs_tag[0];
    assign rs1_value = rs_value[0];
    assign rs2_busy  = rs_busy[1];
    assign rs2_tag   = rs_tag[1];
    assign rs2_value = rs_value[1];

`ifdef RENAME_REGFILE_DEBUG_EN
    logic [31:0] debug_write_count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            debug_write_en    <= 1'b0;
            debug_write_reg   <= '0;
            debug_write_data  <= '0;
            debug_write_count <= '0;
        end else if (rdy_in) begin
            debug_write_en <= commit_valid;
            if (commit_valid) begin
                debug_write_reg   <= commit_reg;
                debug_write_data  <= commit_data;
                debug_write_count <= debug_write_count + 32'd1;
            end
        end
    end
`endif

endmodule
